// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_pkg;

  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned TMO_W           = 32;
  localparam int unsigned UART_BAUD_DIV   = 868;
  localparam int unsigned DEF_ACK_TIMEOUT = 4096;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_NEXT      = 3'd4
  } state_t;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: the first requester after last_i wins.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  int unsigned cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    cand  = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = (32'(last_i) + k) % N;
      if (gnt_o == '0 && req_i[IW'(cand)]) begin
        gnt_o[IW'(cand)] = 1'b1;
        idx_o            = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Schedules byte streams from N_REQ requesters onto one UART transmitter,
// packet-atomic with a per-grant burst limit and handshake timeouts.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned MAX_BURST   = 64,
  parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [BYTE_W*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  output logic [BYTE_W-1:0]         tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int unsigned GW = $clog2(N_REQ);
  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  state_t            state_q, state_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [GW-1:0]     lg_q, lg_d;
  logic [BW-1:0]     burst_q, burst_d, burst_inc;
  logic              last_q, last_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [BYTE_W-1:0] txd_q, txd_d;
  logic              tmo_err_q, tmo_err_d;
  logic              fire;

  logic [BYTE_W-1:0] req_byte [N_REQ];
  logic [N_REQ-1:0]  arb_gnt;
  logic [GW-1:0]     arb_idx;
  logic              sel_valid;
  logic [BYTE_W-1:0] sel_data;
  logic              tmo_hit;

  rr_arbiter #(.N(N_REQ), .IW(GW)) u_arb (
    .req_i  (req_valid),
    .last_i (lg_q),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx)
  );

  always_comb begin
    for (int unsigned k = 0; k < N_REQ; k++) begin
      req_byte[k] = req_data[k*BYTE_W +: BYTE_W];
    end
  end

  assign sel_valid = req_valid[grant_q];
  assign sel_data  = req_byte[grant_q];
  assign tmo_hit   = (tmo_q >= TMO_W'(ACK_TIMEOUT - 1));
  assign burst_inc = (burst_q == BW'(MAX_BURST)) ? burst_q : burst_q + BW'(1);

  // Next-state and handshake decisions; accept/launch is Mealy so that
  // tx_valid is only raised in a cycle where tx_ready is seen high.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    lg_d      = lg_q;
    burst_d   = burst_q;
    last_d    = last_q;
    tmo_d     = tmo_q;
    txd_d     = txd_q;
    tmo_err_d = 1'b0;
    fire      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_gnt != '0) begin
          grant_d = arb_idx;
          burst_d = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (rst_n && tx_ready && sel_valid) begin
          fire    = 1'b1;
          txd_d   = sel_data;
          last_d  = req_last[grant_q];
          tmo_d   = '0;
          state_d = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY, ST_WAIT_DONE: begin
        if ((state_q == ST_WAIT_BUSY) ? !tx_ready : tx_ready) begin
          tmo_d   = '0;
          state_d = (state_q == ST_WAIT_BUSY) ? ST_WAIT_DONE : ST_NEXT;
        end else if (tmo_hit) begin
          tmo_err_d = 1'b1;
          lg_d      = grant_q;
          state_d   = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_NEXT: begin
        burst_d = burst_inc;
        if (last_q || burst_inc == BW'(MAX_BURST)) begin
          lg_d    = grant_q;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      lg_q      <= GW'(N_REQ - 1);
      burst_q   <= '0;
      last_q    <= 1'b0;
      tmo_q     <= '0;
      txd_q     <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      lg_q      <= lg_d;
      burst_q   <= burst_d;
      last_q    <= last_d;
      tmo_q     <= tmo_d;
      txd_q     <= txd_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  // The launched byte is visible during the tx_valid cycle and held after.
  always_comb begin
    req_ready          = '0;
    req_ready[grant_q] = fire;
    tx_valid           = fire;
    tx_data            = fire ? sel_data : txd_q;
  end

  assign grant_id    = grant_q;
  assign busy        = (state_q != ST_IDLE);
  assign timeout_err = tmo_err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a transaction-level arbitration
// model and a per-cycle checker on every launched byte.
module tb_uart_tx_scheduler;

  localparam int NR        = 4;
  localparam int MAX_BURST = 64;
  localparam int DEPTH     = 128;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic [1:0]      grant_id;
  logic            busy;
  logic            timeout_err;

  uart_tx_scheduler dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .grant_id(grant_id),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] sdata [NR][DEPTH];
  logic       slast [NR][DEPTH];
  int         shead [NR];
  int         stail [NR];
  int         mhead [NR];

  int         uart_busy = 1000;
  int         busy_cnt  = 0;
  logic       stuck_next = 1'b0;
  int         tmo_event  = -1;

  int         m_lg = NR - 1;
  int         m_cur = 0;
  int         m_burst = 0;
  logic       m_in_pkt = 1'b0;

  int         ev_cnt = 0;
  int         tmo_seen = 0;
  int         rr0_pulses = 0;
  logic [1:0] log_g [512];
  logic [7:0] log_d [512];

  task automatic chk(input string name, input logic ok,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load(input int k, input logic [7:0] d, input logic l);
    sdata[k][stail[k]] = d;
    slast[k][stail[k]] = l;
    stail[k]++;
  endtask

  task automatic model_reset();
    m_lg = NR - 1;
    m_in_pkt = 1'b0;
    m_burst = 0;
    for (int k = 0; k < NR; k++) mhead[k] = stail[k];
  endtask

  // Transaction-level scheduler: which requester/byte must the next launch carry.
  task automatic model_next(output logic [1:0] g, output logic [7:0] d);
    logic found;
    logic l;
    if (!m_in_pkt) begin
      found = 1'b0;
      for (int i = 1; i <= NR; i++) begin
        int c;
        c = (m_lg + i) % NR;
        if (!found && mhead[c] < stail[c]) begin
          found = 1'b1;
          m_cur = c;
        end
      end
      m_burst = 0;
      m_in_pkt = 1'b1;
    end
    g = 2'(m_cur);
    d = sdata[m_cur][mhead[m_cur]];
    l = slast[m_cur][mhead[m_cur]];
    mhead[m_cur]++;
    m_burst++;
    if (l || m_burst == MAX_BURST || ev_cnt == tmo_event) begin
      m_in_pkt = 1'b0;
      m_lg = m_cur;
    end
  endtask

  // Requester queues and UART model: ready falls the cycle after a launch.
  initial begin
    logic [NR-1:0] rr;
    logic tv;
    for (int k = 0; k < NR; k++) begin shead[k] = 0; stail[k] = 0; end
    req_valid = '0; req_data = '0; req_last = '0; tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      rr = req_ready;
      tv = tx_valid;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        for (int k = 0; k < NR; k++) shead[k] = stail[k];
        tx_ready = 1'b1;
        busy_cnt = 0;
      end else begin
        for (int k = 0; k < NR; k++) if (rr[k]) shead[k]++;
        if (tv) begin
          if (stuck_next) stuck_next = 1'b0;
          else begin tx_ready = 1'b0; busy_cnt = uart_busy; end
        end else if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0) tx_ready = 1'b1;
        end
      end
      for (int k = 0; k < NR; k++) begin
        req_valid[k]       = (shead[k] < stail[k]);
        req_data[8*k +: 8] = (shead[k] < stail[k]) ? sdata[k][shead[k]] : 8'h00;
        req_last[k]        = (shead[k] < stail[k]) ? slast[k][shead[k]] : 1'b0;
      end
    end
  end

  // Per-cycle checker against the model.
  initial begin
    logic [1:0] eg;
    logic [7:0] ed;
    logic       have_last;
    logic [7:0] last_data;
    have_last = 1'b0;
    last_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have_last = 1'b0;
      end else begin
        chk("req_ready_onehot0", $onehot0(req_ready), 32'(req_ready), 32'h0);
        if (tx_valid) begin
          model_next(eg, ed);
          chk("tx_data", tx_data == ed, 32'(tx_data), 32'(ed));
          chk("grant_id", grant_id == eg, 32'(grant_id), 32'(eg));
          chk("req_ready", req_ready == 4'(1 << eg), 32'(req_ready), 32'(1 << eg));
          chk("tx_valid_needs_ready", tx_ready, 32'(tx_ready), 32'h1);
          if (ev_cnt < 512) begin log_g[ev_cnt] = grant_id; log_d[ev_cnt] = tx_data; end
          if (req_ready[0]) rr0_pulses++;
          ev_cnt++;
          have_last = 1'b1;
          last_data = tx_data;
        end else begin
          chk("req_ready_idle", req_ready == '0, 32'(req_ready), 32'h0);
          if (have_last) chk("tx_data_hold", tx_data == last_data, 32'(tx_data), 32'(last_data));
        end
        if (timeout_err) begin
          tmo_seen++;
          chk("busy_at_timeout", !busy, 32'(busy), 32'h0);
        end
      end
    end
  end

  task automatic reset_and_check();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready == '0, 32'(req_ready), 32'h0);
    chk("rst_tx_valid", tx_valid == 1'b0, 32'(tx_valid), 32'h0);
    chk("rst_tx_data", tx_data == 8'h00, 32'(tx_data), 32'h0);
    chk("rst_busy", busy == 1'b0, 32'(busy), 32'h0);
    chk("rst_timeout_err", timeout_err == 1'b0, 32'(timeout_err), 32'h0);
    chk("rst_grant_id", grant_id == 2'd0, 32'(grant_id), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    chk("post_rst_quiet", tx_valid == 1'b0 && req_ready == '0, 32'({req_ready, tx_valid}), 32'h0);
    #1;
  endtask

  task automatic wait_events(input int target, input int budget);
    for (int i = 0; i < budget && ev_cnt < target; i++) @(posedge clk);
    chk("event_budget", ev_cnt >= target, 32'(ev_cnt), 32'(target));
  endtask

  task automatic wait_idle(input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      done = !busy && req_valid == '0;
    end
    chk("idle_budget", done, 32'(busy), 32'h0);
    #1;
  endtask

  initial begin
    int b;
    int t0;
    rst_n = 1'b0;
    reset_and_check();

    // Two-byte packet from requester 0 against a slow UART.
    uart_busy = 1000;
    b = ev_cnt; t0 = rr0_pulses;
    load(0, 8'hA5, 1'b0);
    load(0, 8'h3C, 1'b1);
    wait_events(b + 2, 5000);
    wait_idle(3000);
    chk("t1_byte0", log_d[b] == 8'hA5, 32'(log_d[b]), 32'hA5);
    chk("t1_byte1", log_d[b+1] == 8'h3C, 32'(log_d[b+1]), 32'h3C);
    chk("t1_rr0_pulses", rr0_pulses - t0 == 2, 32'(rr0_pulses - t0), 32'd2);

    // Four simultaneous one-byte packets from reset.
    reset_and_check();
    uart_busy = 3;
    b = ev_cnt;
    for (int k = 0; k < NR; k++) load(k, 8'(8'h11 * (k + 1)), 1'b1);
    wait_events(b + 4, 500);
    wait_idle(200);
    for (int k = 0; k < NR; k++)
      chk("t2_grant_order", log_g[b+k] == 2'(k), 32'(log_g[b+k]), 32'(k));

    // Burst cap: requester 1 streams 70 bytes while requester 2 waits.
    reset_and_check();
    b = ev_cnt;
    for (int i = 0; i < 70; i++) load(1, 8'(i), i == 69);
    load(2, 8'hE0, 1'b0);
    load(2, 8'hE1, 1'b1);
    wait_events(b + 72, 3000);
    wait_idle(200);
    chk("t3_byte63_grant", log_g[b+63] == 2'd1, 32'(log_g[b+63]), 32'd1);
    chk("t3_byte64_grant", log_g[b+64] == 2'd2, 32'(log_g[b+64]), 32'd2);
    chk("t3_byte64_data", log_d[b+64] == 8'hE0, 32'(log_d[b+64]), 32'hE0);
    chk("t3_resume_grant", log_g[b+66] == 2'd1, 32'(log_g[b+66]), 32'd1);
    chk("t3_resume_data", log_d[b+66] == 8'd64, 32'(log_d[b+66]), 32'd64);
    chk("t3_final_data", log_d[b+71] == 8'd69, 32'(log_d[b+71]), 32'd69);

    // Stuck UART: one timeout, packet dropped, next requester served.
    b = ev_cnt; t0 = tmo_seen;
    tmo_event = ev_cnt;
    stuck_next = 1'b1;
    load(2, 8'h77, 1'b0);
    load(2, 8'h78, 1'b1);
    load(3, 8'h88, 1'b1);
    wait_events(b + 3, 6000);
    wait_idle(200);
    chk("t4_timeouts", tmo_seen - t0 == 1, 32'(tmo_seen - t0), 32'd1);
    chk("t4_first", log_g[b] == 2'd2 && log_d[b] == 8'h77, 32'(log_d[b]), 32'h77);
    chk("t4_next_grant", log_g[b+1] == 2'd3, 32'(log_g[b+1]), 32'd3);
    chk("t4_rearb", log_g[b+2] == 2'd2 && log_d[b+2] == 8'h78, 32'(log_d[b+2]), 32'h78);

    // Reset while waiting for the UART to finish.
    uart_busy = 1000;
    b = ev_cnt;
    load(1, 8'h5A, 1'b1);
    wait_events(b + 1, 100);
    repeat (20) @(negedge clk);
    chk("t5_mid_handshake", busy == 1'b1, 32'(busy), 32'h1);
    reset_and_check();
    uart_busy = 3;
    b = ev_cnt;
    load(0, 8'hC0, 1'b1);
    load(1, 8'hC1, 1'b1);
    wait_events(b + 2, 500);
    wait_idle(200);
    chk("t5_first_grant", log_g[b] == 2'd0 && log_d[b] == 8'hC0, 32'(log_g[b]), 32'd0);
    chk("t5_second_grant", log_g[b+1] == 2'd1, 32'(log_g[b+1]), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter N_REQ, default 4: number of byte-stream requesters (2..8).
REQ-002 Parameter MAX_BURST, default 64: maximum bytes sent per grant before re-arbitration.
REQ-003 Parameter ACK_TIMEOUT, default 4096: cycles to wait for each downstream handshake phase.
REQ-004 clk  in  1  single clock for all logic; rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 req_valid  in  N_REQ  requester i has a byte on req_data[i].
REQ-007 req_data  in  8*N_REQ  byte of requester i at bits [8i+7:8i].
REQ-008 req_last  in  N_REQ  byte is the final byte of requester i's packet.
REQ-009 req_ready  out  N_REQ  one-cycle accept strobe; the byte is consumed when req_valid[i] and req_ready[i] are both high.
REQ-010 tx_data  out  8  byte to the UART transmitter; held stable from issue until done.
REQ-011 tx_valid  out  1  one-cycle pulse that launches a UART byte.
REQ-012 tx_ready  in  1  UART idle/ready; it drops while the UART is transmitting.
REQ-013 grant_id  out  $clog2(N_REQ)  index of the current or most recent granted requester.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 timeout_err  out  1  one-cycle pulse when a handshake phase times out.

Function
REQ-016 States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, NEXT. Encoding comes from the shared package.
REQ-017 IDLE: if any req_valid is high, grant round-robin starting at (last_grant+1) mod N_REQ. Load grant_id, clear burst_cnt, go to ISSUE. Arbitration takes 1 cycle.
REQ-018 ISSUE: requires tx_ready=1 and req_valid[grant]=1. Latch the byte into tx_data and latch req_last. Pulse req_ready[grant] and tx_valid in the same cycle. Go to WAIT_BUSY.
REQ-019 ISSUE with req_valid[grant]=0: hold and wait; the grant is kept, because a packet is atomic.
REQ-020 WAIT_BUSY: wait for tx_ready=0, then go to WAIT_DONE. A tx_ready low seen in the cycle directly after the tx_valid pulse counts.
REQ-021 WAIT_DONE: wait for tx_ready=1, then go to NEXT.
REQ-022 NEXT: increment burst_cnt (saturating width $clog2(MAX_BURST+1)).
  - Latched last=1: go to IDLE.
  - burst_cnt reaches MAX_BURST: go to IDLE; the grant is released and last_grant is updated.
  - Otherwise: go to ISSUE with the same grant.
REQ-023 last_grant updates only on leaving NEXT for IDLE. A requester whose burst was cut short by MAX_BURST is re-arbitrated behind the others.
REQ-024 At most one req_ready bit is high in any cycle. req_ready is high only in ISSUE during the accept cycle.
REQ-025 tx_valid is never asserted unless tx_ready=1 in that cycle. At most one tx_valid pulse is outstanding per byte.
REQ-026 Timeout counter: 32 bits.
  - Cleared on entry to WAIT_BUSY and to WAIT_DONE.
  - Increments each cycle spent in either state.
  - Reaching ACK_TIMEOUT: pulse timeout_err, go to IDLE, update last_grant, and drop the rest of the current packet at the arbitration level.
REQ-027 Simultaneous requests: exactly one grant. Requester (last_grant+1) mod N_REQ has the highest priority.
REQ-028 A requester deasserting req_valid while another is granted has no effect on the current grant.
REQ-029 grant_id holds its value in IDLE.

Reset
REQ-030 With rst_n=0 at a clk edge, the following take effect in that edge and hold while rst_n=0:
  - state=IDLE, req_ready=0, tx_valid=0, tx_data=8'h00, busy=0, timeout_err=0.
  - grant_id=0, last_grant=N_REQ-1 (so requester 0 wins first), burst_cnt=0, timeout counter=0.
REQ-031 Reset mid-packet abandons the packet. No req_ready or tx_valid is generated in the reset cycle or the first cycle after release.

Structure
REQ-032 Shared package uart_pkg holds state_t (3-bit enum) and BYTE_W=8. The UART baud and timeout constants also live there.
REQ-033 One sub-module, rr_arbiter: combinational round-robin priority pick.
  - Inputs: request vector and last_grant.
  - Outputs: one-hot grant and index.
REQ-034 The UART transmitter is instantiated outside this block. This block drives only its tx_data/tx_valid and reads tx_ready.

Verification
REQ-035 Single requester 0 sends packet 8'hA5, 8'h3C with last on the 2nd byte, against a UART model (ready drops 1 cycle after valid, rises 1000 cycles later) -> two tx_valid pulses, tx_data 8'hA5 then 8'h3C, and req_ready[0] pulses twice.
REQ-036 Requesters 0..3 all valid from reset, each sending a 1-byte packet -> grant order 0,1,2,3, and grant_id matches at each tx_valid.
REQ-037 Requester 1 streams 70 bytes without last (MAX_BURST=64) while requester 2 is waiting -> after byte 64 requester 2 is served, then requester 1 resumes.
REQ-038 UART model never drops tx_ready after tx_valid -> after ACK_TIMEOUT cycles, one timeout_err pulse, busy=0, and the next requester is granted.
REQ-039 rst_n=0 asserted during WAIT_DONE -> all outputs take their reset values at the next edge, and the first grant after release goes to requester 0.
REQ-040 Assertions hold throughout all runs:
  - req_ready is one-hot or zero.
  - tx_valid implies tx_ready.
  - tx_data is stable from WAIT_BUSY through NEXT.
